// File: rtl/shift_divider.sv
// rtl/shift_divider.sv - sequential restoring unsigned divider, one quotient bit per clock
module shift_divider #(
   parameter int n = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [n-1:0]   D,
   input  logic [n-1:0]   Nin,
   output logic [2*n-1:0] RQ,
   output logic           ready,
   output logic           div_by_zero
);

   localparam int CW = (n > 2) ? $clog2(n) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(n - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [2*n-1:0]  rq_q, rq_d;
   logic [n-1:0]    m_q, m_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            dbz_q, dbz_d;

   // Trial subtraction of the shifted-in partial remainder against the divisor;
   // the borrow bit decides whether the subtraction is kept (restoring step).
   logic [n:0]      trial;
   logic [n:0]      diff;
   logic            fits;

   assign trial = {rq_q[2*n-1:n], rq_q[n-1]};
   assign diff  = trial - {1'b0, m_q};
   assign fits  = ~diff[n];

   // Sequencer and datapath next-state: load on accepted start, iterate in RUN.
   always_comb begin
      state_d = state_q;
      rq_d    = rq_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               rq_d    = {{n{1'b0}}, Nin};
               m_d     = D;
               cnt_d   = '0;
               dbz_d   = (D == '0);
               state_d = RUN;
            end
         end
         RUN: begin
            if (fits) begin
               rq_d = {diff[n-1:0], rq_q[n-2:0], 1'b1};
            end else begin
               rq_d = {trial[n-1:0], rq_q[n-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset aborts any division in flight immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rq_q    <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rq_q    <= rq_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
      end
   end

   assign RQ          = rq_q;
   assign ready       = (state_q == IDLE);
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_divider.sv
// tb/tb_shift_divider.sv - randomized and exhaustive self-checking bench for shift_divider
module tb_shift_divider;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] D     = '0;
   logic [3:0] Nin   = '0;
   logic [7:0] RQ;
   logic       ready;
   logic       div_by_zero;

   int tests = 0;
   int fails = 0;

   shift_divider #(.n(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .D           (D),
      .Nin         (Nin),
      .RQ          (RQ),
      .ready       (ready),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division; D=0 yields all-ones quotient and R=Nin.
   function automatic logic [7:0] ref_rq(input int nin, input int d);
      int q, r;
      if (d == 0) begin
         q = 15;
         r = nin;
      end else begin
         q = nin / d;
         r = nin % d;
      end
      return {r[3:0], q[3:0]};
   endfunction

   // Pulse start with the given operands, scramble operands afterwards,
   // then count busy cycles until ready returns (bounded).
   task automatic do_div(input int nin, input int d, output int busy);
      @(negedge clock);
      start = 1'b1;
      Nin   = nin[3:0];
      D     = d[3:0];
      @(negedge clock);
      start = 1'b0;
      Nin   = 4'($urandom);
      D     = 4'($urandom);
      busy  = 0;
      while (!ready && busy < 20) begin
         busy++;
         @(negedge clock);
      end
   endtask

   initial begin
      int busy;
      int a, b;
      int k, pending_n, pending_d, have_pending, cyc, since;

      // Reset state
      #12;
      check("reset_rq", RQ, 8'h00);
      check("reset_ready", ready, 1'b1);
      check("reset_dbz", div_by_zero, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // Basic 13/4
      do_div(13, 4, busy);
      check("basic_busy", busy, 4);
      check("basic_rq", RQ, 8'h13);
      check("basic_dbz", div_by_zero, 1'b0);

      // Edge quotients
      do_div(15, 1, busy);  check("q_15_1", RQ, 8'h0F);
      do_div(5, 7, busy);   check("q_5_7", RQ, 8'h50);
      do_div(0, 3, busy);   check("q_0_3", RQ, 8'h00);
      do_div(15, 15, busy); check("q_15_15", RQ, 8'h01);

      // Divide by zero then clear
      do_div(9, 0, busy);
      check("dz_rq", RQ, 8'h9F);
      check("dz_flag", div_by_zero, 1'b1);
      @(negedge clock);
      check("dz_hold", div_by_zero, 1'b1);
      do_div(6, 2, busy);
      check("dz_clear_rq", RQ, 8'h03);
      check("dz_clear_flag", div_by_zero, 1'b0);

      // Busy start is ignored
      @(negedge clock);
      start = 1'b1; Nin = 4'd14; D = 4'd3;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      start = 1'b1; Nin = 4'd0; D = 4'd1;
      @(negedge clock);
      start = 1'b0;
      busy = 0;
      while (!ready && busy < 20) begin
         busy++;
         @(negedge clock);
      end
      check("busy_start_ready", ready, 1'b1);
      check("busy_start_rq", RQ, 8'h24);

      // Reset mid-operation
      @(negedge clock);
      start = 1'b1; Nin = 4'd11; D = 4'd2;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("mid_reset_rq", RQ, 8'h00);
      check("mid_reset_ready", ready, 1'b1);
      check("mid_reset_dbz", div_by_zero, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      do_div(11, 2, busy);
      check("after_reset_busy", busy, 4);
      check("after_reset_rq", RQ, 8'h15);

      // Random pulsed divisions
      for (int i = 0; i < 40; i++) begin
         a = $urandom_range(0, 15);
         b = $urandom_range(0, 15);
         do_div(a, b, busy);
         check("rand_busy", busy, 4);
         check($sformatf("rand_rq_%0d_%0d", a, b), RQ, ref_rq(a, b));
         check("rand_dbz", div_by_zero, (b == 0));
      end

      // Exhaustive back-to-back sweep with start held high
      @(negedge clock);
      start = 1'b1;
      k = 0;
      have_pending = 0;
      pending_n = 0;
      pending_d = 0;
      cyc = 0;
      since = 0;
      while (cyc < 2000 && (k < 256 || have_pending == 1)) begin
         if (ready) begin
            if (have_pending == 1) begin
               check("b2b_busy", since, 4);
               check($sformatf("b2b_rq_%0d_%0d", pending_n, pending_d), RQ,
                     ref_rq(pending_n, pending_d));
               check("b2b_dbz", div_by_zero, (pending_d == 0));
               have_pending = 0;
            end
            if (k < 256) begin
               pending_n = k / 16;
               pending_d = k % 16;
               Nin = pending_n[3:0];
               D   = pending_d[3:0];
               have_pending = 1;
               k++;
            end else begin
               start = 1'b0;
            end
            since = 0;
         end else begin
            since++;
            Nin = 4'($urandom);
            D   = 4'($urandom);
         end
         @(negedge clock);
         cyc++;
      end
      start = 1'b0;
      check("b2b_complete", (k == 256 && have_pending == 0), 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_divider.md
# shift_divider

Sequential restoring (shift-subtract) unsigned integer divider. It is the inverse companion of the shift-add multiplier and shares its datapath style: a double-width shift register holding remainder and quotient, an n-bit trial subtractor, and a small sequencer. The block retires one quotient bit per clock. Remainder and quotient are packed into a single 2n-bit output.

## Interface
- `n`, default 4: operand width in bits; must be ≥ 2.

- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a division; sampled only while `ready`=1.
- `D`  in  n  divisor, unsigned; captured on the start edge.
- `Nin`  in  n  dividend, unsigned; captured on the start edge.
- `RQ`  out  2n  `RQ[2n-1:n]` is the remainder (A); `RQ[n-1:0]` is the quotient (Q).
- `ready`  out  1  1 = idle and result valid; 0 = busy.
- `div_by_zero`  out  1  1 when the current or last operation had `D`=0.

## Operation
- Internal state:
  - `RQ` register {A, Q}.
  - Latched divisor `M` (n bits).
  - Iteration counter (⌈log2 n⌉ bits).
  - Two-state FSM: IDLE, RUN.
- Reset (asynchronous, any time, including mid-division):
  - `RQ`=0, `M`=0, counter=0.
  - FSM goes to IDLE, `ready`=1, `div_by_zero`=0.
- IDLE:
  - `ready`=1 and `RQ` holds the last result.
  - On an edge with `start`=1, the block loads A=0, Q=`Nin`, M=`D`, counter=0, `div_by_zero`=(`D`==0), and moves to RUN.
- RUN, each edge performs one iteration:
  - Form T = {A, Q[n-1]} (n+1 bits).
  - Compute diff = T − {1'b0, M} (n+1 bits).
  - If T ≥ M: A ← diff[n-1:0] and Q ← {Q[n-2:0], 1}.
  - Else: A ← T[n-1:0] and Q ← {Q[n-2:0], 0}.
  - Counter increments by 1. On the iteration where counter = n−1, the FSM returns to IDLE.
- Result: Q = floor(Nin/D), A = Nin mod D. A < M always holds, so A fits in n bits.
- Divide by zero needs no special datapath. The algorithm itself yields Q = 2^n−1 and A = `Nin`.
  - `div_by_zero` flags this case.
  - `div_by_zero` holds its value until the next accepted start or reset.
- `start` while busy (RUN) is ignored. The operation in flight is unaffected.
- `D` and `Nin` may change freely after the start edge.

## Timing
- Start edge = edge E0, with `start`=1 and `ready`=1. `ready` falls after E0.
- Iterations occur on edges E1..En. `ready` rises after En, and the final `RQ` is valid from then on.
- Latency: n+1 edges from the start edge to the result, including E0. Throughput is one division per n+1 cycles.
- During RUN, `RQ` shows partial remainder and quotient. It is not valid.
- `div_by_zero` is valid from the edge after E0.
- If `start` is held high continuously, a new operation is accepted on the edge after `ready` rises. The result is then visible for exactly one cycle. This back-to-back behaviour is legal and required.
- Reset asserted during RUN aborts the division immediately (asynchronously). The first start after reset deasserts behaves normally.

## Test plan
- **Basic (n=4):** `Nin`=13, `D`=4, pulse `start`.
  - `ready` is 0 for 4 cycles, then 1.
  - `RQ`=8'h13 (R=1, Q=3), `div_by_zero`=0.
- **Edge quotients:**
  - 15/1 → `RQ`=8'h0F.
  - 5/7 → `RQ`=8'h50.
  - 0/3 → `RQ`=8'h00.
  - 15/15 → `RQ`=8'h01.
- **Divide by zero:** 9/0 → `RQ`=8'h9F and `div_by_zero`=1. The next division, 6/2, clears the flag and gives `RQ`=8'h03.
- **Busy-start and operand change:**
  - Start 14/3, then pulse `start` again in cycle 2 with `D`=1 and `Nin`=0.
  - The second start is ignored.
  - `RQ`=8'h24 after 5 cycles.
- **Reset mid-operation:**
  - Assert `reset` during cycle 2 of 11/2.
  - Immediately `RQ`=0, `ready`=1, `div_by_zero`=0.
  - A subsequent 11/2 gives `RQ`=8'h15.
- **Exhaustive and back-to-back (n=4):**
  - Hold `start`=1 and sweep all 256 (`Nin`, `D`) pairs.
  - Each result must match a reference model, sampled on each `ready` rise.
  - `D`=0 cases must give Q=4'hF and R=`Nin`.
